seg7_scan_display: RTL and testbench
====================================

Name: seg7_scan_display

Overview:
- Parametrised multiplexed seven-segment driver for an N-digit common-anode display.
- Converts a binary value to BCD with a sequential double-dabble FSM and time-multiplexes the digits.
- Supports four display modes (decimal, PC-prefixed, input prompt, off) and drives the busy indicator LEDs.
- Sits between the processor status/datapath outputs and the board display pins.

Parameters:
- DATA_W, 8, width of the binary input value (4..16).
- NUM_DIGITS, 4, digits on the display (3..8); digit 0 is leftmost.
- CLK_DIV, 1024, clk cycles per scan tick (>=2).
- BLINK_TICKS, 256, scan ticks per blink half-period (used only with BUSY_BLINK_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- value  in  DATA_W  binary value to display.
- mode  in  2  0=DEC, 1=PC, 2=PROMPT, 3=OFF.
- busy  in  1  processor busy flag.
- seg  out  7  segment drive, active-low, bit6=g .. bit0=a.
- an  out  NUM_DIGITS  digit enables, active-low; an[0] is leftmost.
- s_led  out  8  status LEDs.
- conv_busy  out  1  high while a BCD conversion is in progress.

Behaviour:
- Reset values (asynchronous, immediate):
  - seg=7'h7F, an all ones, s_led=0, conv_busy=0.
  - Prescaler=0, scan index=0, FSM=IDLE.
  - Latched value=0, display BCD=0, overflow=0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and pulses tick on the terminal count, then returns to 0.
  - The scan index advances on tick and wraps from NUM_DIGITS-1 to 0.
- seg and an are registered and update on tick. an is one-hot low at the scan index; a blanked digit drives an all ones.
- Converter FSM:
  - IDLE: if value != latched value, latch value, clear BCD shift register (4*NUM_DIGITS bits plus carry-out detect), load count=DATA_W, set conv_busy, go SHIFT.
  - SHIFT: each clk, add 3 to every nibble >=5, then shift {bcd,bin} left by 1 and decrement count. When count reaches 0, go DONE.
  - DONE: copy BCD and overflow to the display registers, clear conv_busy, go IDLE.
  - Latency: value change to display register update is DATA_W+2 clk. The old digits are shown until DONE.
  - A value change during SHIFT is ignored. It is re-detected in IDLE by comparison with the latched value, which triggers a new conversion; no value is lost at its final settled state.
- Overflow: set when value > 10^NUM_DIGITS-1. All digits then show '-' (7'b0111111) in DEC mode.
- Glyphs: 0..9 = 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1011000, 0000000, 0010000.
  - P=0001100, C=1000110, I=1111001, n=1101010, '-'=0111111.
- Modes:
  - DEC: right-aligned decimal. Leading zeros are blanked; the rightmost digit is always shown.
  - PC: digits 0,1 show P,C. The remaining NUM_DIGITS-2 show the low decimal digits, zero-padded and never blanked. Overflow is ignored (truncated).
  - PROMPT: the rightmost three digits show I,n,P; the others are blank.
  - OFF: all blank.
  - Mode is sampled at each tick.
- s_led: registered every clk; 8'hFF when busy=1, 8'h00 otherwise.
- Reset mid-conversion aborts the conversion: FSM to IDLE, display BCD to 0, conv_busy=0.

Optional Feature:
- Macro: BUSY_BLINK_EN.
- Defined: a blink toggle flips every BLINK_TICKS scan ticks while busy=1. When the toggle is high, all an are driven high (display blanked). The toggle is held at 0 while busy=0, so blanking stops immediately on busy falling. s_led is unaffected.
- Undefined: busy affects only s_led.

Test Plan:
- Defaults except CLK_DIV=4. Reset, value=0, mode=DEC -> an cycles 1111 then 1111, 1111, 1110 across ticks 0..3; digit 3 seg=1000000; s_led=0; conv_busy stays 0.
- value 0 -> 173 -> conv_busy high for 9 clk; display BCD=0173 at clk 10. Digits show blank, 1111001, 1011000, 0110000.
- mode=PC, value=5 -> P, C, 0, 5 (0001100, 1000110, 1000000, 0010010). mode=PROMPT -> blank, I, n, P.
- DATA_W=12, NUM_DIGITS=3, value=4095, mode=DEC -> all three digits 0111111. value=999 -> 9, 9, 9.
- value 100, then 200 two clk later (mid-SHIFT) -> display 100 at clk 10, a second conversion starts, display 200 by clk 20; conv_busy drops between the two conversions.
- rst pulse mid-SHIFT -> outputs go to reset values immediately. After release with value=37, shows blank, blank, 3, 7. busy=1 -> s_led=8'hFF the next clk. With BUSY_BLINK_EN and BLINK_TICKS=2, an is all ones for 2 of every 4 ticks.

Source files
------------

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: multiplexed seven-segment driver for an N-digit common-anode display.
// A sequential double-dabble converter turns the binary value into BCD. The scan logic
// then time-multiplexes the digits in one of four modes: decimal, PC-prefixed, prompt or off.
//
// Optional feature macro: BUSY_BLINK_EN. When it is defined, the display blinks while busy=1.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   value      binary value to display (DATA_W bits)
//   mode       0=DEC, 1=PC, 2=PROMPT, 3=OFF
//   busy       processor busy flag
//   seg        segment drive, active-low, bit6=g .. bit0=a
//   an         digit enables, active-low, an[0] is the leftmost digit
//   s_led      status LEDs, all on while busy
//   conv_busy  high while a BCD conversion is in progress
module seg7_scan_display #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned CLK_DIV     = 1024,
  parameter int unsigned BLINK_TICKS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     value,
  input  logic [1:0]            mode,
  input  logic                  busy,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            s_led,
  output logic                  conv_busy
);

  localparam int unsigned BcdW = 4 * NUM_DIGITS;
  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam int unsigned CntW = $clog2(DATA_W + 1);

  localparam logic [1:0] ModeDec    = 2'd0;
  localparam logic [1:0] ModePc     = 2'd1;
  localparam logic [1:0] ModePrompt = 2'd2;

  localparam logic [6:0] GlyphBlank = 7'h7F;
  localparam logic [6:0] GlyphP     = 7'b0001100;
  localparam logic [6:0] GlyphC     = 7'b1000110;
  localparam logic [6:0] GlyphI     = 7'b1111001;
  localparam logic [6:0] GlyphN     = 7'b1101010;
  localparam logic [6:0] GlyphDash  = 7'b0111111;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1011000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = GlyphBlank;
    endcase
    return g;
  endfunction

  // Prescaler and scan index
  logic [DivW-1:0] div_q;
  logic [IdxW-1:0] scan_q;
  logic            tick;

  assign tick = (div_q == DivW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      scan_q <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + DivW'(1);
      if (tick) begin
        scan_q <= (scan_q == IdxW'(NUM_DIGITS - 1)) ? '0 : scan_q + IdxW'(1);
      end
    end
  end

  // Double-dabble converter
  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  // Bit BcdW is a sticky overflow flag that catches any bit shifted out of the top nibble
  logic [BcdW:0]     bcd_q, bcd_d;
  logic [BcdW-1:0]   bcd_adj;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [BcdW-1:0]   disp_bcd_q, disp_bcd_d;
  logic              disp_ovf_q, disp_ovf_d;

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    disp_bcd_d = disp_bcd_q;
    disp_ovf_d = disp_ovf_q;

    bcd_adj = bcd_q[BcdW-1:0];
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (value != val_q) begin
          val_d   = value;
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = CntW'(DATA_W);
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d = {bcd_q[BcdW] | bcd_adj[BcdW-1], bcd_adj[BcdW-2:0], bin_q[DATA_W-1]};
        bin_d = {bin_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        disp_bcd_d = bcd_q[BcdW-1:0];
        disp_ovf_d = bcd_q[BcdW];
        busy_d     = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      val_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      disp_bcd_q <= '0;
      disp_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      disp_bcd_q <= disp_bcd_d;
      disp_ovf_q <= disp_ovf_d;
    end
  end

  assign conv_busy = busy_q;

  // Digit selection and glyph decode
  logic [NUM_DIGITS:0]   lz;       // lz[k]: nibble k and every nibble above it are zero
  logic [3:0]            cur_nib;
  logic                  cur_lz;
  logic                  blank;
  logic [6:0]            glyph_d;
  logic [6:0]            seg_d, seg_q;
  logic [NUM_DIGITS-1:0] an_d, an_q;

  always_comb begin
    lz             = '0;
    lz[NUM_DIGITS] = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      lz[k] = lz[k+1] & (disp_bcd_q[4*k +: 4] == 4'd0);
    end

    // Digit 0 is leftmost, so scan index s shows nibble NUM_DIGITS-1-s
    cur_nib = '0;
    cur_lz  = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (scan_q == IdxW'(int'(NUM_DIGITS) - 1 - k)) begin
        cur_nib = disp_bcd_q[4*k +: 4];
        cur_lz  = lz[k];
      end
    end

    blank   = 1'b0;
    glyph_d = GlyphBlank;
    unique case (mode)
      ModeDec: begin
        if (disp_ovf_q) begin
          glyph_d = GlyphDash;
        end else if (cur_lz && (scan_q != IdxW'(NUM_DIGITS - 1))) begin
          blank = 1'b1;
        end else begin
          glyph_d = digit_glyph(cur_nib);
        end
      end
      ModePc: begin
        if (scan_q == IdxW'(0)) begin
          glyph_d = GlyphP;
        end else if (scan_q == IdxW'(1)) begin
          glyph_d = GlyphC;
        end else begin
          glyph_d = digit_glyph(cur_nib);
        end
      end
      ModePrompt: begin
        if (scan_q == IdxW'(NUM_DIGITS - 3)) begin
          glyph_d = GlyphI;
        end else if (scan_q == IdxW'(NUM_DIGITS - 2)) begin
          glyph_d = GlyphN;
        end else if (scan_q == IdxW'(NUM_DIGITS - 1)) begin
          glyph_d = GlyphP;
        end else begin
          blank = 1'b1;
        end
      end
      default: blank = 1'b1;
    endcase

    seg_d = blank ? GlyphBlank : glyph_d;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      an_d[k] = blank | (scan_q != IdxW'(k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= GlyphBlank;
      an_q  <= '1;
      s_led <= 8'h00;
    end else begin
      if (tick) begin
        seg_q <= seg_d;
        an_q  <= an_d;
      end
      s_led <= busy ? 8'hFF : 8'h00;
    end
  end

  assign seg = seg_q;

`ifdef BUSY_BLINK_EN
  localparam int unsigned BlkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [BlkW-1:0] blink_cnt_q;
  logic            blink_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (!busy) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (tick) begin
      if (blink_cnt_q == BlkW'(BLINK_TICKS - 1)) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BlkW'(1);
      end
    end
  end

  // Gated with busy so blanking stops in the same cycle busy falls
  assign an = an_q | {NUM_DIGITS{blink_q & busy}};
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = (BLINK_TICKS == 0);
  assign an = an_q;
`endif

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  value;
  logic [11:0] value2;
  logic [1:0]  mode;
  logic        busy;
  logic [6:0]  seg, seg2;
  logic [3:0]  an;
  logic [2:0]  an2;
  logic [7:0]  s_led, s_led2;
  logic        conv_busy, conv_busy2;

  always #5 clk = ~clk;

  seg7_scan_display #(.DATA_W(8), .NUM_DIGITS(4), .CLK_DIV(4), .BLINK_TICKS(256)) dut (
    .clk(clk), .rst(rst), .value(value), .mode(mode), .busy(busy),
    .seg(seg), .an(an), .s_led(s_led), .conv_busy(conv_busy)
  );

  seg7_scan_display #(.DATA_W(12), .NUM_DIGITS(3), .CLK_DIV(4), .BLINK_TICKS(256)) dut2 (
    .clk(clk), .rst(rst), .value(value2), .mode(mode), .busy(busy),
    .seg(seg2), .an(an2), .s_led(s_led2), .conv_busy(conv_busy2)
  );

  // Clock edges since reset release; with CLK_DIV=4 the outputs refresh on edges 4,8,12,...
  // and edge 4k shows digit (k-1) mod NUM_DIGITS.
  int unsigned cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  logic [6:0] seg_cap[4];
  logic [3:0] an_cap[4];
  logic [6:0] seg2_cap[3];
  logic [2:0] an2_cap[3];

  always begin
    @(posedge clk);
    #1;
    if (!rst && cyc != 0 && cyc % 4 == 0) begin
      seg_cap[(cyc / 4 - 1) % 4]  = seg;
      an_cap[(cyc / 4 - 1) % 4]   = an;
      seg2_cap[(cyc / 4 - 1) % 3] = seg2;
      an2_cap[(cyc / 4 - 1) % 3]  = an2;
    end
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // show[i]=1: digit i lit with glyph e[i]; show[i]=0: digit i blank
  task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3, input logic [3:0] show);
    logic [6:0] e[4];
    logic [3:0] ea;
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      ea = 4'hF;
      if (show[i]) ea[i] = 1'b0;
      check($sformatf("%s seg%0d", tag, i), 32'(seg_cap[i]), 32'(show[i] ? e[i] : 7'h7F));
      check($sformatf("%s an%0d", tag, i), 32'(an_cap[i]), 32'(ea));
    end
  endtask

  task automatic check_frame2(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2);
    logic [6:0] e[3];
    logic [2:0] ea;
    e = '{e0, e1, e2};
    for (int i = 0; i < 3; i++) begin
      ea = 3'b111;
      ea[i] = 1'b0;
      check($sformatf("%s seg%0d", tag, i), 32'(seg2_cap[i]), 32'(e[i]));
      check($sformatf("%s an%0d", tag, i), 32'(an2_cap[i]), 32'(ea));
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic       cb;
  int         ones;
  logic       bz[32];

  initial begin
    rst    = 1'b1;
    value  = 8'd0;
    value2 = 12'd0;
    mode   = 2'd0;
    busy   = 1'b0;
    #1;
    check("rst seg", 32'(seg), 32'h7F);
    check("rst an", 32'(an), 32'hF);
    check("rst s_led", 32'(s_led), 32'h00);
    check("rst conv_busy", 32'(conv_busy), 32'h0);
    check("rst an2", 32'(an2), 32'h7);

    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // value 0 in DEC: only the rightmost digit lit, converter never starts
    cb = 1'b0;
    repeat (16) begin
      @(posedge clk);
      #1;
      cb |= conv_busy;
    end
    #1;
    check_frame("zero", 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b1000);
    check("zero conv_busy idle", 32'(cb), 32'h0);
    check("zero s_led", 32'(s_led), 32'h00);

    // 0 -> 173: conv_busy high for edges 1..9, low again after edge 10
    value = 8'd173;
    ones  = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      bz[i] = conv_busy;
      if (conv_busy) ones++;
    end
    #1;
    check("173 busy count", 32'(ones), 32'd9);
    check("173 busy edge1", 32'(bz[1]), 32'h1);
    check("173 busy edge9", 32'(bz[9]), 32'h1);
    check("173 busy edge10", 32'(bz[10]), 32'h0);
    wait_clk(32);
    check_frame("dec173", 7'h7F, 7'h79, 7'h58, 7'h30, 4'b1110);

    mode  = 2'd1;
    value = 8'd5;
    wait_clk(44);
    check_frame("pc5", 7'h0C, 7'h46, 7'h40, 7'h12, 4'b1111);

    mode = 2'd2;
    wait_clk(20);
    check_frame("prompt", 7'h7F, 7'h79, 7'h6A, 7'h0C, 4'b1110);

    mode = 2'd3;
    wait_clk(20);
    check_frame("off", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000);

    // 12-bit value on the 3-digit instance: overflow shows dashes
    mode   = 2'd0;
    value2 = 12'd4095;
    wait_clk(44);
    check_frame2("ovf4095", 7'h3F, 7'h3F, 7'h3F);
    value2 = 12'd999;
    wait_clk(44);
    check_frame2("dec999", 7'h10, 7'h10, 7'h10);

    // 100 then 200 two edges later, while the first conversion is shifting
    value = 8'd100;
    wait_clk(2);
    value = 8'd200;
    ones  = 0;
    for (int i = 3; i <= 22; i++) begin
      @(posedge clk);
      #1;
      bz[i] = conv_busy;
      if (conv_busy) ones++;
    end
    #1;
    check("race busy edge9", 32'(bz[9]), 32'h1);
    check("race busy gap edge10", 32'(bz[10]), 32'h0);
    check("race busy restart edge11", 32'(bz[11]), 32'h1);
    check("race busy edge19", 32'(bz[19]), 32'h1);
    check("race busy end edge20", 32'(bz[20]), 32'h0);
    check("race busy count", 32'(ones), 32'd16);
    wait_clk(32);
    check_frame("dec200", 7'h7F, 7'h24, 7'h40, 7'h40, 4'b1110);

    // Reset in the middle of a conversion with busy raised
    busy  = 1'b1;
    value = 8'd37;
    wait_clk(3);
    check("pre-rst conv_busy", 32'(conv_busy), 32'h1);
    check("pre-rst s_led", 32'(s_led), 32'hFF);
    rst = 1'b1;
    #1;
    check("midrst seg", 32'(seg), 32'h7F);
    check("midrst an", 32'(an), 32'hF);
    check("midrst s_led", 32'(s_led), 32'h00);
    check("midrst conv_busy", 32'(conv_busy), 32'h0);
    busy = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    wait_clk(44);
    check_frame("dec37", 7'h7F, 7'h7F, 7'h30, 7'h58, 4'b1100);

    // s_led is registered: follows busy one edge later
    busy = 1'b1;
    #1;
    check("s_led before edge", 32'(s_led), 32'h00);
    @(posedge clk);
    #1;
    check("s_led busy", 32'(s_led), 32'hFF);
    busy = 1'b0;
    @(posedge clk);
    #1;
    check("s_led idle", 32'(s_led), 32'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
